io_sequencer: RTL and testbench

//  Top-level sequencer for the accelerator IO path. Steps the load phase (filter stream, then image

---
 rtl/io_pkg.sv | 28 ++
 rtl/io_watchdog.sv | 28 ++
 rtl/io_sequencer.sv | 124 ++++++++++++
 tb/tb_io_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared types and defaults for the accelerator IO sequencer.
// State encoding, stream base addresses and the registered output bundle.
package io_pkg;

  localparam int          RES_W          = 4;
  localparam logic [15:0] FILTER_BASE_D  = 16'h0000;
  localparam logic [15:0] IMAGE_BASE_D   = 16'h0400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_FILTER,
    S_LD_IMAGE,
    S_LOADED,
    S_RUN,
    S_REPORT,
    S_ERR
  } state_t;

  typedef struct packed {
    logic             decomp_en;
    logic [15:0]      base_addr;
    logic             cnn_start;
    logic             done;
    logic             error;
    logic [RES_W-1:0] dout;
  } seq_out_t;

endpackage

// File: rtl/io_watchdog.sv
// Saturating idle counter; flags the idle cycle that reaches LIMIT.
// timeout is combinational so the sequencer can act on that same edge.
module io_watchdog #(
  parameter int W     = 13,
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic timeout
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign timeout = inc && (cnt >= W'(LIMIT - 1));

endmodule

// File: rtl/io_sequencer.sv
// Load/infer sequencer for the accelerator IO path.
// Steps filter then image streams, launches the CNN and reports the class.
module io_sequencer
  import io_pkg::*;
#(
  parameter logic [15:0] FILTER_BASE = FILTER_BASE_D,
  parameter logic [15:0] IMAGE_BASE  = IMAGE_BASE_D,
  parameter int          MAX_WORDS   = 1024,
  parameter int          TIMEOUT     = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             cnn,
  input  logic             stream_end,
  input  logic             word_wr,
  input  logic             cnn_done,
  input  logic [RES_W-1:0] cnn_result,
  output logic             decomp_en,
  output logic [15:0]      base_addr,
  output logic             cnn_start,
  output logic             done,
  output logic             error,
  output logic [RES_W-1:0] Dout
);

  state_t      state, state_nxt;
  seq_out_t    o_q, o_nxt;
  logic [10:0] word_cnt, word_cnt_nxt, word_inc;
  logic        loading, overflow, wd_timeout, go_load;

  assign loading  = (state == S_LD_FILTER) || (state == S_LD_IMAGE);
  assign word_inc = (word_cnt == '1) ? word_cnt : word_cnt + 11'd1;
  assign overflow = loading && word_wr && (word_cnt >= 11'(MAX_WORDS));

  // Any non-loading cycle or stored word restarts the idle window.
  io_watchdog #(
    .W     (13),
    .LIMIT (TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (!loading || word_wr),
    .inc     (loading && !word_wr),
    .timeout (wd_timeout)
  );

  always_comb begin
    state_nxt       = state;
    o_nxt           = o_q;
    o_nxt.cnn_start = 1'b0;
    o_nxt.done      = 1'b0;
    word_cnt_nxt    = word_cnt;
    go_load         = 1'b0;
    if (loading && word_wr) word_cnt_nxt = word_inc;
    unique case (state)
      S_IDLE: go_load = load;
      S_LD_FILTER, S_LD_IMAGE: begin
        if (overflow || wd_timeout) begin
          state_nxt       = S_ERR;
          o_nxt.error     = 1'b1;
          o_nxt.decomp_en = 1'b0;
        end else if (stream_end) begin
          if (state == S_LD_FILTER) begin
            state_nxt       = S_LD_IMAGE;
            o_nxt.base_addr = IMAGE_BASE;
            word_cnt_nxt    = '0;
          end else begin
            state_nxt       = S_LOADED;
            o_nxt.decomp_en = 1'b0;
            o_nxt.done      = 1'b1;
          end
        end
      end
      S_LOADED: begin
        if (cnn) begin
          state_nxt       = S_RUN;
          o_nxt.cnn_start = 1'b1;
        end else begin
          go_load = load;
        end
      end
      S_RUN: begin
        if (cnn_done) begin
          state_nxt  = S_REPORT;
          o_nxt.dout = cnn_result;
          o_nxt.done = 1'b1;
        end
      end
      S_REPORT: state_nxt = S_LOADED;
      S_ERR:    go_load = load;
      default:  state_nxt = S_IDLE;
    endcase
    if (go_load) begin
      state_nxt       = S_LD_FILTER;
      o_nxt.decomp_en = 1'b1;
      o_nxt.base_addr = FILTER_BASE;
      o_nxt.error     = 1'b0;
      word_cnt_nxt    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      word_cnt <= '0;
      o_q      <= '{decomp_en: 1'b0, base_addr: FILTER_BASE,
                    cnn_start: 1'b0, done: 1'b0, error: 1'b0,
                    dout: '0};
    end else begin
      state    <= state_nxt;
      word_cnt <= word_cnt_nxt;
      o_q      <= o_nxt;
    end
  end

  assign decomp_en = o_q.decomp_en;
  assign base_addr = o_q.base_addr;
  assign cnn_start = o_q.cnn_start;
  assign done      = o_q.done;
  assign error     = o_q.error;
  assign Dout      = o_q.dout;

endmodule

// File: tb/tb_io_sequencer.sv
// Bench for io_sequencer: directed scenarios plus random traffic,
// every cycle compared against a phase-level reference model.
module tb_io_sequencer;

  localparam int MAXW = 1024;
  localparam int TOUT = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0, cnn = 1'b0, stream_end = 1'b0;
  logic       word_wr = 1'b0, cnn_done = 1'b0;
  logic [3:0] cnn_result = 4'h0;
  logic       decomp_en, cnn_start, done, error;
  logic [15:0] base_addr;
  logic [3:0] Dout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  io_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .cnn        (cnn),
    .stream_end (stream_end),
    .word_wr    (word_wr),
    .cnn_done   (cnn_done),
    .cnn_result (cnn_result),
    .decomp_en  (decomp_en),
    .base_addr  (base_addr),
    .cnn_start  (cnn_start),
    .done       (done),
    .error      (error),
    .Dout       (Dout)
  );

  // Reference model: phase name plus plain integer counters.
  typedef enum int {P_IDLE, P_FIL, P_IMG, P_READY, P_INFER, P_SHOW, P_FAULT} phase_t;
  phase_t     ph;
  int         words, idle;
  logic       m_en, m_start, m_done, m_err;
  logic [15:0] m_base;
  logic [3:0] m_dout;

  function automatic logic [23:0] exp_vec();
    return {m_en, m_base, m_start, m_done, m_err, m_dout};
  endfunction

  function automatic logic [23:0] dut_vec();
    return {decomp_en, base_addr, cnn_start, done, error, Dout};
  endfunction

  task automatic mdl_reset();
    ph = P_IDLE; words = 0; idle = 0;
    m_en = 0; m_start = 0; m_done = 0; m_err = 0;
    m_base = 16'h0000; m_dout = 4'h0;
  endtask

  task automatic mdl_begin_load();
    ph = P_FIL; words = 0; idle = 0;
    m_en = 1; m_err = 0; m_base = 16'h0000;
  endtask

  task automatic mdl_step();
    m_start = 0;
    m_done  = 0;
    case (ph)
      P_IDLE: if (load) mdl_begin_load();
      P_FIL, P_IMG: begin
        if (word_wr) begin
          words++;
          idle = 0;
        end else begin
          idle++;
        end
        if (words > MAXW || idle >= TOUT) begin
          ph = P_FAULT; m_err = 1; m_en = 0;
        end else if (stream_end && ph == P_FIL) begin
          ph = P_IMG; m_base = 16'h0400; words = 0;
        end else if (stream_end) begin
          ph = P_READY; m_en = 0; m_done = 1;
        end
      end
      P_READY: begin
        if (cnn) begin
          ph = P_INFER; m_start = 1;
        end else if (load) begin
          mdl_begin_load();
        end
      end
      P_INFER: if (cnn_done) begin
        ph = P_SHOW; m_dout = cnn_result; m_done = 1;
      end
      P_SHOW:  ph = P_READY;
      P_FAULT: if (load) mdl_begin_load();
      default: ph = P_IDLE;
    endcase
  endtask

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h (en,base,start,done,err,dout) want %h", tag, got, want);
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    mdl_step();
    #1;
    chk(tag, dut_vec(), exp_vec());
  endtask

  task automatic tick(input string tag, input logic l, input logic c,
                      input logic se, input logic ww, input logic cd,
                      input logic [3:0] r);
    load = l; cnn = c; stream_end = se; word_wr = ww;
    cnn_done = cd; cnn_result = r;
    cyc(tag);
  endtask

  task automatic idle_ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag, 0, 0, 0, 0, 0, 4'h0);
  endtask

  task automatic do_reset();
    load = 0; cnn = 0; stream_end = 0; word_wr = 0; cnn_done = 0;
    rst = 0;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset", dut_vec(), exp_vec());
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    do_reset();

    // 1: filter stream of 3 words, image stream of 2 words
    tick("t1_load", 1, 0, 0, 0, 0, 4'h0);
    for (int i = 0; i < 3; i++) tick("t1_fword", 0, 0, 0, 1, 0, 4'h0);
    tick("t1_fend", 0, 0, 1, 0, 0, 4'h0);
    for (int i = 0; i < 2; i++) tick("t1_iword", 0, 0, 0, 1, 0, 4'h0);
    tick("t1_iend", 0, 0, 1, 0, 0, 4'h0);
    tick("t1_loaded", 0, 0, 0, 0, 0, 4'h0);

    // 2: inference with result 7 after 20 cycles
    tick("t2_cnn", 0, 1, 0, 0, 0, 4'h0);
    idle_ticks("t2_wait", 19);
    tick("t2_cdone", 0, 0, 0, 0, 1, 4'h7);
    tick("t2_back", 0, 0, 0, 0, 0, 4'h0);
    tick("t2_cnn_again", 0, 1, 0, 0, 0, 4'h0);
    tick("t2_cdone2", 0, 0, 0, 0, 1, 4'hc);
    idle_ticks("t2_hold", 2);

    // 3: overflow on the 1025th word
    tick("t3_reload", 1, 0, 0, 0, 0, 4'h0);
    for (int i = 0; i < MAXW + 1; i++) tick("t3_word", 0, 0, 0, 1, 0, 4'h0);
    tick("t3_cnn_ign", 0, 1, 0, 0, 0, 4'h0);
    idle_ticks("t3_stay", 3);

    // 4: timeout in the image stream
    tick("t4_load", 1, 0, 0, 0, 0, 4'h0);
    tick("t4_fend_ww", 0, 0, 1, 1, 0, 4'h0);
    idle_ticks("t4_idle", TOUT - 1);
    tick("t4_expire", 0, 0, 0, 0, 0, 4'h0);
    tick("t4_clear", 1, 0, 0, 0, 0, 4'h0);
    tick("t4_empty1", 0, 0, 1, 0, 0, 4'h0);
    tick("t4_empty2", 0, 0, 1, 0, 0, 4'h0);

    // 5: load wins in IDLE, cnn wins in LOADED
    do_reset();
    tick("t5_both_idle", 1, 1, 0, 0, 0, 4'h0);
    tick("t5_fend", 0, 0, 1, 0, 0, 4'h0);
    tick("t5_iend", 0, 0, 1, 0, 0, 4'h0);
    tick("t5_both_ldd", 1, 1, 0, 0, 0, 4'h0);
    tick("t5_run_ign", 1, 1, 0, 0, 0, 4'h0);

    // 6: asynchronous reset while running
    load = 0; cnn = 0;
    @(posedge clk);
    mdl_step();
    #3;
    rst = 0;
    mdl_reset();
    #1;
    chk("t6_async", dut_vec(), exp_vec());
    @(negedge clk);
    rst = 1;
    tick("t6_cnn_ign", 0, 1, 0, 0, 0, 4'h0);
    idle_ticks("t6_after", 2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tick("rand",
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 0,
           $urandom_range(0, 5) == 0,
           4'($urandom));
    end
    idle_ticks("rand_tail", 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
